rect_renderer: RTL and testbench

RECT_RENDERER -- requirements
Module: rect_renderer

---
 rtl/rect_renderer_if.sv | 33 +++
 rtl/rect_renderer.sv | 154 +++++++++++++++
 tb/tb_rect_renderer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rect_renderer_if.sv
// Pixel-request / pixel-stream bundle between a rectangle client and the
// renderer. The client drives the request fields and out_ready; the renderer
// drives the pixel stream and status flags.
interface rect_renderer_if #(
   parameter int X_W    = 8,
   parameter int Y_W    = 7,
   parameter int SIZE_W = 4
);
   logic              start;
   logic [X_W-1:0]    x0;
   logic [Y_W-1:0]    y0;
   logic [SIZE_W-1:0] w;
   logic [SIZE_W-1:0] h;
   logic              mode;
   logic [2:0]        colour_in;
   logic              out_ready;
   logic [X_W-1:0]    r_x;
   logic [Y_W-1:0]    r_y;
   logic [2:0]        r_colour;
   logic              writeEn;
   logic              busy;
   logic              done;

   modport master (
      output start, x0, y0, w, h, mode, colour_in, out_ready,
      input  r_x, r_y, r_colour, writeEn, busy, done
   );

   modport slave (
      input  start, x0, y0, w, h, mode, colour_in, out_ready,
      output r_x, r_y, r_colour, writeEn, busy, done
   );
endinterface

// File: rtl/rect_renderer.sv
// Rectangle rasteriser: walks a w x h box in raster order, one candidate per
// cycle, and streams visible pixels with a valid/ready style hold.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; request fields are captured on start
// DRAW   | scanning candidates (cx, cy); stalls while a pixel is refused
// DONE   | one-cycle completion flag, then back to IDLE
//
// All outputs are registered from the *next* candidate, so the pixel on the
// outputs always corresponds to the current (r_cx, r_cy). A stalled pixel is
// held simply because the counters do not move.
module rect_renderer #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int SIZE_W   = 4,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input logic              clk,
   input logic              resetn,
   rect_renderer_if.slave   bus
);

   typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

   state_t            r_state, w_nxt_state;
   logic [SIZE_W-1:0] r_cx, r_cy, w_nxt_cx, w_nxt_cy;
   logic [X_W-1:0]    r_x0;
   logic [Y_W-1:0]    r_y0;
   logic [SIZE_W-1:0] r_w, r_h;
   logic              r_mode;
   logic [2:0]        r_col;

   logic [X_W-1:0]    r_out_x;
   logic [Y_W-1:0]    r_out_y;
   logic [2:0]        r_out_col;
   logic              r_we, r_busy, r_done;

   logic              w_in_idle, w_advance, w_last_col, w_last_row;
   logic [X_W-1:0]    w_ox;
   logic [Y_W-1:0]    w_oy;
   logic [SIZE_W-1:0] w_w, w_h;
   logic              w_mode;
   logic [2:0]        w_col;
   logic [X_W:0]      w_sum_x;
   logic [Y_W:0]      w_sum_y;
   logic              w_vis, w_edge, w_nxt_we;

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_nxt_state;
   end

   // Next-state and scan-counter logic
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cx    = r_cx;
      w_nxt_cy    = r_cy;
      w_advance   = !r_we || bus.out_ready;
      w_last_col  = (r_cx == r_w - 1'b1);
      w_last_row  = (r_cy == r_h - 1'b1);
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_nxt_cx = '0;
               w_nxt_cy = '0;
               if (bus.w == '0 || bus.h == '0) w_nxt_state = S_DONE;
               else                            w_nxt_state = S_DRAW;
            end
         end
         S_DRAW: begin
            if (w_advance) begin
               if (w_last_col && w_last_row) begin
                  w_nxt_state = S_DONE;
                  w_nxt_cx    = '0;
                  w_nxt_cy    = '0;
               end else if (w_last_col) begin
                  w_nxt_cx = '0;
                  w_nxt_cy = r_cy + 1'b1;
               end else begin
                  w_nxt_cx = r_cx + 1'b1;
               end
            end
         end
         S_DONE:  w_nxt_state = S_IDLE;
         default: w_nxt_state = S_IDLE;
      endcase
   end

   // Candidate pixel for the next cycle; the first candidate uses the live
   // request so it can appear on the outputs right after start is sampled
   always_comb begin
      w_in_idle = (r_state == S_IDLE);
      w_ox      = w_in_idle ? bus.x0        : r_x0;
      w_oy      = w_in_idle ? bus.y0        : r_y0;
      w_w       = w_in_idle ? bus.w         : r_w;
      w_h       = w_in_idle ? bus.h         : r_h;
      w_mode    = w_in_idle ? bus.mode      : r_mode;
      w_col     = w_in_idle ? bus.colour_in : r_col;
      w_sum_x   = (X_W+1)'(w_ox) + (X_W+1)'(w_nxt_cx);
      w_sum_y   = (Y_W+1)'(w_oy) + (Y_W+1)'(w_nxt_cy);
      w_vis     = (w_sum_x < (X_W+1)'(SCREEN_W)) && (w_sum_y < (Y_W+1)'(SCREEN_H));
      w_edge    = !w_mode || (w_nxt_cx == '0) || (w_nxt_cx == w_w - 1'b1)
                  || (w_nxt_cy == '0) || (w_nxt_cy == w_h - 1'b1);
      w_nxt_we  = (w_nxt_state == S_DRAW) && w_vis && w_edge;
   end

   // Request capture, scan counters and registered outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cx      <= '0;
         r_cy      <= '0;
         r_x0      <= '0;
         r_y0      <= '0;
         r_w       <= '0;
         r_h       <= '0;
         r_mode    <= 1'b0;
         r_col     <= '0;
         r_out_x   <= '0;
         r_out_y   <= '0;
         r_out_col <= '0;
         r_we      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         if (w_in_idle && bus.start) begin
            r_x0   <= bus.x0;
            r_y0   <= bus.y0;
            r_w    <= bus.w;
            r_h    <= bus.h;
            r_mode <= bus.mode;
            r_col  <= bus.colour_in;
         end
         r_cx      <= w_nxt_cx;
         r_cy      <= w_nxt_cy;
         r_out_x   <= w_sum_x[X_W-1:0];
         r_out_y   <= w_sum_y[Y_W-1:0];
         r_out_col <= w_col;
         r_we      <= w_nxt_we;
         r_busy    <= (w_nxt_state != S_IDLE);
         r_done    <= (w_nxt_state == S_DONE);
      end
   end

   assign bus.r_x      = r_out_x;
   assign bus.r_y      = r_out_y;
   assign bus.r_colour = r_out_col;
   assign bus.writeEn  = r_we;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;

endmodule

// File: tb/tb_rect_renderer.sv
// Scoreboard bench for rect_renderer: stimulus queues the expected pixels,
// a negedge monitor pops and compares every accepted pixel and checks that
// refused pixels are held stable.
module tb_rect_renderer;

   typedef struct {
      int x;
      int y;
      int c;
   } pix_t;

   logic clk;
   logic resetn;
   logic tog;
   int   n_checks;
   int   n_fail;
   pix_t sb[$];

   rect_renderer_if #(.X_W(8), .Y_W(7), .SIZE_W(4)) bus ();

   rect_renderer #(
      .X_W(8), .Y_W(7), .SIZE_W(4), .SCREEN_W(160), .SCREEN_H(120)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // out_ready: constantly 1, or toggling every cycle when tog is set
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = tog ? ~bus.out_ready : 1'b1;
      end
   end

   // Monitor: compare accepted pixels against the scoreboard, check holds
   logic       prev_stall;
   logic [17:0] prev_out;
   initial prev_stall = 1'b0;
   always @(negedge clk) begin
      if (!resetn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            check("stall_hold", int'({bus.r_x, bus.r_y, bus.r_colour}), int'(prev_out));
         if (bus.writeEn && bus.out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_pixel", int'({bus.r_x, bus.r_y, bus.r_colour}), -1);
            end else begin
               pix_t e;
               e = sb.pop_front();
               check("pixel", int'({bus.r_x, bus.r_y, bus.r_colour}),
                     (e.x << 10) | (e.y << 3) | e.c);
            end
         end
         prev_stall = bus.writeEn && !bus.out_ready;
         prev_out   = {bus.r_x, bus.r_y, bus.r_colour};
      end
   end

   // Reference: raster walk over the box, keep on-screen (outline) pixels
   task automatic push_expected(input int x, input int y, input int ww, input int hh,
                                input bit m, input int col);
      for (int yy = 0; yy < hh; yy++) begin
         for (int xx = 0; xx < ww; xx++) begin
            if ((x + xx) < 160 && (y + yy) < 120 &&
                (!m || xx == 0 || xx == ww - 1 || yy == 0 || yy == hh - 1)) begin
               pix_t p;
               p.x = x + xx;
               p.y = y + yy;
               p.c = col;
               sb.push_back(p);
            end
         end
      end
   endtask

   task automatic run_rect(input int x, input int y, input int ww, input int hh,
                           input bit m, input int col, input int exp_done,
                           input bit restart);
      int got;
      push_expected(x, y, ww, hh, m, col);
      @(posedge clk);
      #1;
      bus.x0        = 8'(x);
      bus.y0        = 7'(y);
      bus.w         = 4'(ww);
      bus.h         = 4'(hh);
      bus.mode      = m;
      bus.colour_in = 3'(col);
      bus.start     = 1'b1;
      @(posedge clk);
      #1;
      bus.start     = 1'b0;
      bus.x0        = 8'd50;
      bus.y0        = 7'd50;
      bus.w         = 4'd7;
      bus.h         = 4'd7;
      bus.mode      = ~m;
      bus.colour_in = 3'(~col);
      got = -1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (restart && c == 0) bus.start = 1'b1;
         if (c == 1) bus.start = 1'b0;
         if (c == 0) check("busy_first", int'(bus.busy), 1);
         if (bus.done) begin
            got = c;
            break;
         end
      end
      if (exp_done >= 0) check("done_cycle", got, exp_done);
      else               check("done_seen", int'(got >= 0), 1);
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_done", int'(bus.busy), 0);
      check("done_one_cycle", int'(bus.done), 0);
      repeat (3) @(negedge clk);
      check("queue_drained", sb.size(), 0);
      check("idle_after", int'(bus.busy), 0);
   endtask

   initial begin
      bit bad;
      pix_t p;
      n_checks      = 0;
      n_fail        = 0;
      tog           = 1'b0;
      resetn        = 1'b1;
      bus.start     = 1'b0;
      bus.x0        = '0;
      bus.y0        = '0;
      bus.w         = '0;
      bus.h         = '0;
      bus.mode      = 1'b0;
      bus.colour_in = '0;
      #2;
      resetn = 1'b0;
      #1;
      check("reset_outputs", int'({bus.r_x, bus.r_y, bus.r_colour, bus.writeEn}), 0);
      check("reset_status", int'({bus.busy, bus.done}), 0);
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;

      // filled 4x4 at (10,20), colour 5
      run_rect(10, 20, 4, 4, 1'b0, 5, 16, 1'b0);
      // outline 3x3 at origin, centre skipped but still costs a cycle
      run_rect(0, 0, 3, 3, 1'b1, 3, 9, 1'b0);
      // clipped against the right and bottom screen edges
      run_rect(158, 119, 4, 2, 1'b0, 6, 8, 1'b0);
      // backpressure: out_ready toggling every cycle
      tog = 1'b1;
      run_rect(40, 40, 2, 2, 1'b0, 2, -1, 1'b0);
      tog = 1'b0;
      // zero width: straight to DONE, start during DONE ignored
      run_rect(5, 5, 0, 3, 1'b0, 1, 0, 1'b1);
      // start pulse during DRAW ignored
      run_rect(5, 5, 3, 2, 1'b0, 1, 6, 1'b1);
      // degenerate outlines: single column and single row
      run_rect(20, 10, 1, 4, 1'b1, 4, 4, 1'b0);
      run_rect(60, 70, 5, 1, 1'b1, 7, 5, 1'b0);
      // outline 4x4
      run_rect(100, 100, 4, 4, 1'b1, 7, 16, 1'b0);

      // reset in the middle of an 8x8 at the 5th pixel
      for (int i = 0; i < 5; i++) begin
         p.x = 30 + i;
         p.y = 30;
         p.c = 3;
         sb.push_back(p);
      end
      @(posedge clk);
      #1;
      bus.x0        = 8'd30;
      bus.y0        = 7'd30;
      bus.w         = 4'd8;
      bus.h         = 4'd8;
      bus.mode      = 1'b0;
      bus.colour_in = 3'd3;
      bus.start     = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check("midreset_outputs", int'({bus.r_x, bus.r_y, bus.r_colour, bus.writeEn}), 0);
      check("midreset_status", int'({bus.busy, bus.done}), 0);
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.writeEn || bus.busy || bus.done) bad = 1'b1;
      end
      check("idle_after_reset", int'(bad), 0);
      check("reset_queue", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
